// File: rtl/chunked_serial_adder_pkg.sv
// chunked_serial_adder_pkg: FSM encodings and index sizing shared by the chunked adder
package chunked_serial_adder_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chunked_serial_adder_ripple_chunk.sv
// chunked_serial_adder_ripple_chunk: N-bit combinational ripple slice exposing the carry into its MSB
module chunked_serial_adder_ripple_chunk #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_ci,
  output logic [N-1:0] o_s,
  output logic         o_co,
  output logic         o_c_msb
);
  logic [N:0] w_c;
  assign w_c[0] = i_ci;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end
  assign o_co    = w_c[N];
  assign o_c_msb = w_c[N-1];
endmodule

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: valid/ready add/subtract that time-shares one CHUNK-bit ripple slice
module chunked_serial_adder
  import chunked_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = idx_w(NCHUNK);
  if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_chk
    $error("WIDTH must be a positive multiple of CHUNK");
  end
  logic [1:0]       r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry, r_cout, r_ovf;
  logic [IW-1:0]    r_idx;
  logic [CHUNK-1:0] w_ca, w_cb, w_s;
  logic             w_co, w_cmsb, w_acc, w_last;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == S_IDLE && w_acc) ? S_RUN :
             (r_state == S_RUN && w_last) ? S_DONE :
             (r_state == S_DONE && i_out_ready) ? S_IDLE : r_state;
  end
  always_comb begin
    o_in_ready  = (r_state == S_IDLE) && i_rst_n;
    o_out_valid = (r_state == S_DONE);
  end
  // Operand chunk currently fed to the shared slice
  always_comb begin
    w_acc  = i_in_valid && o_in_ready;
    w_last = (r_idx == IW'(NCHUNK - 1));
    w_ca   = '0;
    w_cb   = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (r_idx == IW'(c)) begin
        w_ca = r_a[c*CHUNK +: CHUNK];
        w_cb = r_b[c*CHUNK +: CHUNK];
      end
    end
  end
  chunked_serial_adder_ripple_chunk #(.N(CHUNK)) u_slice (
    .i_a    (w_ca),
    .i_b    (w_cb),
    .i_ci   (r_carry),
    .o_s    (w_s),
    .o_co   (w_co),
    .o_c_msb(w_cmsb)
  );
  // B is stored pre-inverted and the carry pre-seeded so RUN is a plain add
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_acc) begin
      r_a     <= i_a;
      r_b     <= i_sub ? ~i_b : i_b;
      r_carry <= i_cin ^ i_sub;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      for (int c = 0; c < NCHUNK; c++) begin
        if (r_idx == IW'(c)) r_sum[c*CHUNK +: CHUNK] <= w_s;
      end
      r_carry <= w_co;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_co;
        r_ovf  <= w_co ^ w_cmsb;
      end
    end
  end
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder: directed table on an 8/4 adder plus random sweeps on 16-bit adders
module tb_chunked_serial_adder;
  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;
  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    res_t        e;
    int          stall;
    bit          early;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = '0, out_ready = '0, cin = '0, sub = '0;
  logic [3:0]  in_ready, out_valid, cout, ovf;
  logic [15:0] a = '0, b = '0;
  logic [7:0]  s0;
  logic [15:0] s1, s2, s3;
  res_t        q[$];
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  chunked_serial_adder #(.WIDTH(8), .CHUNK(4)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
    .i_a(a[7:0]), .i_b(b[7:0]), .i_cin(cin[0]), .i_sub(sub[0]), .o_out_valid(out_valid[0]),
    .i_out_ready(out_ready[0]), .o_sum(s0), .o_cout(cout[0]), .o_ovf(ovf[0]));
  chunked_serial_adder #(.WIDTH(16), .CHUNK(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
    .i_a(a), .i_b(b), .i_cin(cin[1]), .i_sub(sub[1]), .o_out_valid(out_valid[1]),
    .i_out_ready(out_ready[1]), .o_sum(s1), .o_cout(cout[1]), .o_ovf(ovf[1]));
  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]),
    .i_a(a), .i_b(b), .i_cin(cin[2]), .i_sub(sub[2]), .o_out_valid(out_valid[2]),
    .i_out_ready(out_ready[2]), .o_sum(s2), .o_cout(cout[2]), .o_ovf(ovf[2]));
  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[3]), .o_in_ready(in_ready[3]),
    .i_a(a), .i_b(b), .i_cin(cin[3]), .i_sub(sub[3]), .o_out_valid(out_valid[3]),
    .i_out_ready(out_ready[3]), .o_sum(s3), .o_cout(cout[3]), .o_ovf(ovf[3]));

  function automatic logic [15:0] sum_of(input int k);
    return (k == 0) ? {8'h00, s0} : (k == 1) ? s1 : (k == 2) ? s2 : s3;
  endfunction

  function automatic int nc(input int k);
    return (k == 0) ? 2 : (k == 1) ? 16 : (k == 2) ? 4 : 1;
  endfunction

  function automatic res_t model(input int w, input logic [15:0] ia, ib, input logic icin, isub);
    logic [16:0] full;
    logic [15:0] m, aa, bb;
    res_t r;
    m    = (w == 16) ? 16'hFFFF : 16'h00FF;
    aa   = ia & m;
    bb   = (isub ? ~ib : ib) & m;
    full = {1'b0, aa} + {1'b0, bb} + {16'h0, icin ^ isub};
    r.s  = full[15:0] & m;
    r.c  = full[w];
    r.o  = (aa[w-1] == bb[w-1]) && (r.s[w-1] != aa[w-1]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic op(input int k, input logic [15:0] ia, ib, input logic icin, isub,
                    input res_t e, input int stall, input bit early);
    int   t, lat;
    res_t got, ex;
    t = 0;
    @(negedge clk);
    while (!in_ready[k] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_idle", {31'h0, in_ready[k]}, 1);
    if (!in_ready[k]) return;
    a = ia;
    b = ib;
    cin[k] = icin;
    sub[k] = isub;
    in_valid[k] = 1'b1;
    out_ready[k] = early && (stall == 0);
    @(posedge clk);
    q.push_back(e);
    @(negedge clk);
    in_valid[k] = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    cin[k] = 1'($urandom);
    sub[k] = 1'($urandom);
    lat = 0;
    while (!out_valid[k] && lat < 40) begin
      chk("in_ready_run", {31'h0, in_ready[k]}, 0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, nc(k));
    if (!out_valid[k]) begin
      q.delete();
      return;
    end
    got = {sum_of(k), cout[k], ovf[k]};
    for (int j = 0; j < stall; j++) begin
      in_valid[k] = (j < 2);
      a = 16'($urandom);
      @(negedge clk);
      chk("hold_result", {15'h0, sum_of(k), cout[k], ovf[k]}, {15'h0, got});
      chk("in_ready_done", {31'h0, in_ready[k]}, 0);
      chk("out_valid_hold", {31'h0, out_valid[k]}, 1);
    end
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b1;
    @(posedge clk);
    if (q.size() == 0) chk("scoreboard_empty", 1, 0);
    else begin
      ex = q.pop_front();
      chk("sum", {16'h0, got.s}, {16'h0, ex.s});
      chk("cout", {31'h0, got.c}, {31'h0, ex.c});
      chk("ovf", {31'h0, got.o}, {31'h0, ex.o});
    end
    @(negedge clk);
    out_ready[k] = 1'b0;
    chk("in_ready_after", {31'h0, in_ready[k]}, 1);
    chk("out_valid_after", {31'h0, out_valid[k]}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   seen;
    tbl[0] = '{16'h00FF, 16'h00FF, 1'b0, 1'b0, '{16'h00FE, 1'b1, 1'b0}, 5, 1'b0};
    tbl[1] = '{16'h007F, 16'h0001, 1'b0, 1'b0, '{16'h0080, 1'b0, 1'b1}, 0, 1'b1};
    tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, '{16'h00FE, 1'b0, 1'b0}, 1, 1'b0};
    tbl[3] = '{16'h0080, 16'h0001, 1'b1, 1'b1, '{16'h007E, 1'b1, 1'b1}, 0, 1'b0};
    tbl[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, '{16'h0001, 1'b0, 1'b0}, 2, 1'b0};
    tbl[5] = '{16'h000F, 16'h0001, 1'b0, 1'b0, '{16'h0010, 1'b0, 1'b0}, 0, 1'b1};
    tbl[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0}, 3, 1'b0};
    tbl[7] = '{16'h0080, 16'h0080, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}, 0, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {28'h0, in_ready}, 0);
    chk("rst_out_valid", {28'h0, out_valid}, 0);
    chk("rst_flags", {24'h0, cout, ovf}, 0);
    chk("rst_sums", {s0, s1 | s2 | s3}, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {28'h0, in_ready}, 32'hF);

    foreach (tbl[i]) op(0, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].e, tbl[i].stall, tbl[i].early);

    @(negedge clk);
    a = 16'h00FF;
    b = 16'h00FF;
    cin[0] = 1'b1;
    sub[0] = 1'b0;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_rst_in_ready", {31'h0, in_ready[0]}, 0);
    chk("midrun_rst_out", {15'h0, out_valid[0], s0, 6'h0, cout[0], ovf[0]}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_rel_in_ready", {31'h0, in_ready[0]}, 1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    chk("midrun_no_result", seen, 0);
    out_ready[0] = 1'b0;

    for (int k = 1; k < 4; k++) begin
      for (int n = 0; n < 500; n++) begin
        logic [15:0] ra, rb;
        logic rc, rs;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        op(k, ra, rb, rc, rs, model(16, ra, rb, rc, rs), $urandom_range(0, 3), 1'($urandom));
      end
    end
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
